// File: rtl/seq_mult_hs_pkg.sv
// rtl/seq_mult_hs_pkg.sv - shared state encoding and width helper for seq_mult_hs
package seq_mult_hs_pkg;

  // Controller states; 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Product width for a given operand width
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mult_hs_add_ripple_n.sv
// rtl/seq_mult_hs_add_ripple_n.sv - parametrised N-bit ripple-carry adder
module add_ripple_n #(
  parameter int N = 8
) (
  output logic [N-1:0] sum,
  output logic         cout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[N];

endmodule

// File: rtl/seq_mult_hs.sv
// rtl/seq_mult_hs.sv - sequential shift-add multiplier with valid/ready handshakes
module seq_mult_hs
  import seq_mult_hs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             mlier,
  input  logic [WIDTH-1:0]             mcand,
  input  logic                         tc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [prod_width(WIDTH)-1:0] prodt,
  output logic                         busy
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_mlier;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_prodt;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_mlier_abs;
  logic [WIDTH-1:0] w_mcand_abs;
  logic [PW-1:0]    w_sum;
  logic             w_cout;
  logic             w_unused;

  // Magnitudes are taken only for signed operands with the MSB set;
  // the most negative value maps onto its own unsigned magnitude.
  assign w_mlier_abs = (tc && mlier[WIDTH-1]) ? (~mlier + WIDTH'(1)) : mlier;
  assign w_mcand_abs = (tc && mcand[WIDTH-1]) ? (~mcand + WIDTH'(1)) : mcand;
  assign w_last      = (r_cnt == LAST_STEP);

  // The product of two magnitudes never overflows 2*WIDTH, so cout stays 0
  add_ripple_n #(.N(PW)) u_add (
    .sum  (w_sum),
    .cout (w_cout),
    .a    (r_acc),
    .b    (r_mcand),
    .cin  (1'b0)
  );

  assign w_unused = w_cout;
  assign prodt    = r_prodt;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; in_ready in DONE follows out_ready
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = ST_SIGN;
        end
      end
      ST_SIGN: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = ST_CALC;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, fixed WIDTH-step accumulate, sign fix-up
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mlier <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_prodt <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else if (w_accept) begin
      r_mlier <= w_mlier_abs;
      r_mcand <= {{WIDTH{1'b0}}, w_mcand_abs};
      r_neg   <= (mlier[WIDTH-1] ^ mcand[WIDTH-1]) & tc;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CALC: begin
          if (r_mlier[0]) begin
            r_acc <= w_sum;
          end
          r_mcand <= r_mcand << 1;
          r_mlier <= r_mlier >> 1;
          r_cnt   <= r_cnt + CW'(1);
        end
        ST_SIGN: begin
          r_prodt <= r_neg ? (~r_acc + PW'(1)) : r_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb/tb_seq_mult_hs.sv - directed and random self-checking bench for seq_mult_hs
module tb_seq_mult_hs;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic        reset;
  logic        in_valid, out_ready, tc;
  logic [31:0] mlier, mcand;
  logic        in_ready, out_valid, busy;
  logic [63:0] prodt;

  logic        b_in_valid, b_out_ready, b_tc;
  logic [7:0]  b_mlier, b_mcand;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_prodt;

  seq_mult_hs #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mlier(mlier), .mcand(mcand), .tc(tc), .out_valid(out_valid),
    .out_ready(out_ready), .prodt(prodt), .busy(busy)
  );

  seq_mult_hs #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mlier(b_mlier), .mcand(b_mcand), .tc(b_tc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .prodt(b_prodt), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] ref64(input logic [31:0] a, input logic [31:0] b, input logic t);
    logic signed [63:0] sa, sb;
    if (t) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [15:0] ref16(input logic [7:0] a, input logic [7:0] b, input logic t);
    logic signed [15:0] sa, sb;
    logic [15:0] p;
    if (t) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      p  = sa * sb;
    end else begin
      p = {8'b0, a} * {8'b0, b};
    end
    return p;
  endfunction

  // One complete WIDTH=32 operation from IDLE, with latency and hold-off checks
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic t, input logic [63:0] exp);
    int n;
    mlier = a; mcand = b; tc = t; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; mlier = $urandom; mcand = $urandom; tc = ~t;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    chk({tag, "_prodt"}, prodt, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  // One WIDTH=8 operation with a random consumer stall
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic t);
    int n;
    int hold;
    logic [15:0] exp;
    exp = ref16(a, b, t);
    b_mlier = a; b_mcand = b; b_tc = t; b_in_valid = 1'b1;
    chk("w8_in_ready", 64'(b_in_ready), 64'd1);
    step();
    b_in_valid = 1'b0; b_mlier = 8'($urandom); b_mcand = 8'($urandom);
    n = 0;
    while (!b_out_valid && n < 50) begin
      step();
      n++;
    end
    chk("w8_latency", 64'(n), 64'd9);
    chk("w8_prodt", 64'(b_prodt), 64'(exp));
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("w8_hold", 64'({b_out_valid, b_in_ready, b_prodt}), 64'({2'b10, exp}));
    end
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int tt[3];
    logic [63:0] ev[3];
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rt;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tc = 1'b0; mlier = '0; mcand = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_tc = 1'b0; b_mlier = '0; b_mcand = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_prodt", prodt, 64'd0);

    op32("mixed", 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    op32("ufull", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    op32("sfull", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    op32("smin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    op32("negzero", 32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0);

    // Backpressure: result held, new pair refused while out_ready is low
    mlier = 32'd1000; mcand = 32'd1000; tc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd33);
    chk("bp_prodt", prodt, 64'd1000000);
    held = prodt;
    in_valid = 1'b1; mlier = 32'd3; mcand = 32'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_stable", prodt, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", 64'({out_valid, busy, in_ready}), 64'b001);

    // Back-to-back with continuous in_valid and out_ready
    ev[0] = 64'd15;
    ev[1] = 64'hFFFF_FFFF_FFFF_FFF4;
    ev[2] = 64'h0000_0001_0000_0000;
    out_ready = 1'b1; in_valid = 1'b1; tc = 1'b0; mlier = 32'd3; mcand = 32'd5;
    step();
    tc = 1'b1; mlier = 32'hFFFF_FFFE; mcand = 32'd6;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        step();
        n++;
      end
      tt[k] = cyc;
      chk("b2b_prodt", prodt, ev[k]);
      step();
      if (k == 0) begin
        tc = 1'b0; mlier = 32'h0001_0000; mcand = 32'h0001_0000;
      end else if (k == 1) begin
        tc = 1'b0; mlier = 32'd9; mcand = 32'd9;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("b2b_period0", 64'(tt[1] - tt[0]), 64'd34);
    chk("b2b_period1", 64'(tt[2] - tt[1]), 64'd34);

    // Reset during CALC step 10 drops the in-flight product
    repeat (9) step();
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_prodt", prodt, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    op32("after_rst", 32'd12, 32'd12, 1'b0, 64'd144);

    // Random sweep at both widths
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rt = 1'($urandom);
      op32("rand32", ra, rb, rt, ref64(ra, rb, rt));
    end
    for (int i = 0; i < 24; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end
    op8(8'h80, 8'h80, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_hs.md
# seq_mult_hs

Parametrised sequential shift-add multiplier with per-operation signed/unsigned mode and valid/ready handshakes on both sides. It is the next-generation arithmetic unit for the datapath: any operand width, backpressure on the result, and a fixed, predictable latency. It consumes one operand pair, runs WIDTH add/shift steps, applies sign correction, and holds the 2*WIDTH-bit product until the consumer takes it.

## Interface
- WIDTH, default 32: operand width in bits; must be at least 2. Product width is 2*WIDTH.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and tc are valid this cycle.
- in_ready  out  1  block can accept an operand pair this cycle.
- mlier  in  WIDTH  multiplier operand.
- mcand  in  WIDTH  multiplicand operand.
- tc  in  1  1 = operands are two's complement; 0 = unsigned.
- out_valid  out  1  prodt holds a finished product.
- out_ready  in  1  consumer takes prodt this cycle.
- prodt  out  2*WIDTH  product. Two's complement when tc=1, otherwise unsigned.
- busy  out  1  a computation is in progress (state CALC or SIGN).

## Operation
- States: IDLE, CALC, SIGN, DONE.
- **IDLE:** in_ready=1. On in_valid, the block latches:
  - |mlier| and |mcand|, taking the absolute value only when tc=1 and the operand MSB is 1;
  - the negate flag, (mlier MSB ^ mcand MSB) & tc;
  - clears the accumulator and loads step counter = 0;
  - then goes to CALC.
- **CALC:** each cycle, if multiplier LSB = 1, accumulator += shifted multiplicand (2*WIDTH add). Then the multiplicand shifts left 1 and the multiplier shifts right 1. After WIDTH steps the block goes to SIGN.
  - No early termination. Latency does not depend on the data.
- **SIGN:** prodt <= negate ? (~acc + 1) : acc, then go to DONE. Negating zero yields zero, so there is no "negative zero".
- **DONE:** out_valid=1 and prodt is held stable.
  - On out_ready the block goes to IDLE.
  - If in_valid is also high in that cycle, it accepts the new pair directly and goes to CALC.
  - in_ready = IDLE | (DONE & out_ready). This is a combinational path from out_ready; it is the only one.
- Width rules:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - min*min = 2^(2*WIDTH-2), which fits as a positive value in 2*WIDTH bits.
  - The adder carry-out is discarded; it can never be set.
- Operand inputs are sampled only at the accept edge. Later changes are ignored.
- **Reset** in any state, including mid-CALC: state=IDLE, accumulator=0, prodt=0. Any in-flight product is lost.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, prodt=0.
- Accept at edge T. CALC occupies the cycles after edges T..T+WIDTH-1. SIGN is the cycle after edge T+WIDTH. out_valid is high after edge T+WIDTH+1.
  - Latency is WIDTH+1 cycles from accept to out_valid (33 for WIDTH=32).
- The result is held for any number of cycles while out_ready=0.
- Back-to-back throughput: one product per WIDTH+2 cycles when out_ready is held high.
- busy rises the cycle after accept and falls when out_valid rises.

## Structure
- Shared package holds:
  - the state enum (IDLE/CALC/SIGN/DONE, 2-bit encoding);
  - a function for the product width, 2*WIDTH.
- One sub-module: add_ripple_n, a parametrised N-bit ripple-carry adder (sum, cout, a, b, cin), instantiated at N = 2*WIDTH for the accumulate step.
- The negation in SIGN reuses no adder; it is an inline increment.

## Test plan
All directed cases use WIDTH=32 unless stated.
- **Signed, mixed signs:** mlier=7, mcand=-3 (0xFFFFFFFD), tc=1 -> prodt=0xFFFFFFFFFFFFFFEB, out_valid exactly 33 cycles after accept.
- **Unsigned full scale:** mlier=mcand=0xFFFFFFFF, tc=0 -> prodt=0xFFFFFFFE00000001. Same pair with tc=1 -> 0x0000000000000001.
- **Signed minimum:** mlier=mcand=0x80000000, tc=1 -> 0x4000000000000000. Then mlier=0, mcand=-5, tc=1 -> prodt=0 (no negative zero).
- **Backpressure:** out_ready=0 for 10 cycles after out_valid -> prodt stable, in_ready=0 throughout. A new in_valid in that window is not accepted.
- **Back-to-back with reset:**
  - Drive in_valid continuously with out_ready=1 -> each product is correct and the period is 34 cycles.
  - Assert reset in CALC step 10 -> the next cycle shows in_ready=1, out_valid=0, prodt=0, busy=0.
  - A fresh 12*12 then returns 144.
- **Random sweep:** random mlier, mcand, tc and out_ready at WIDTH=8 and WIDTH=32 -> every prodt matches a reference model; no handshake violations.
